// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage hazard controller. Inserts load-use bubbles, drives a
// multi-cycle wrong-path flush after taken branches, freezes the back end on
// data-memory wait states, and keeps saturating event counters.
module hazard_unit #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             stat_clr,
    output logic             ctrl_src,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             pipe_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam int unsigned FL_W = $clog2(FLUSH_DEPTH) + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [FL_W-1:0] fl_left, fl_left_nxt;

    logic rs1_used, rs2_used, load_use;
    logic stall_ev, busy_ev;

    // Decode which source registers the IF/ID instruction actually reads.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (if_id_opcode)
            7'b0110011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b0100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
            7'b0010011: rs1_used = 1'b1;
            7'b0000011: rs1_used = 1'b1;
            default: ;
        endcase
        load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                   ((rs1_used && (id_ex_rd == if_id_rs1)) ||
                    (rs2_used && (id_ex_rd == if_id_rs2)));
    end

    // Prioritised output decode and next-state logic; a memory freeze holds all state.
    always_comb begin
        ctrl_src    = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        pipe_en     = 1'b1;
        stall_ev    = 1'b0;
        busy_ev     = 1'b0;
        state_nxt   = state;
        fl_left_nxt = fl_left;

        if (reset) begin
            ctrl_src    = 1'b1;
            if_id_flush = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            busy_ev     = 1'b1;
        end else if (state == FLUSH) begin
            ctrl_src    = 1'b1;
            if_id_flush = 1'b1;
            fl_left_nxt = fl_left - FL_W'(1);
            if (fl_left == FL_W'(1)) begin
                state_nxt = RUN;
            end
        end else if (branch_taken) begin
            ctrl_src    = 1'b1;
            if_id_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_nxt   = FLUSH;
                fl_left_nxt = FL_W'(FLUSH_DEPTH - 1);
            end
        end else if (load_use) begin
            ctrl_src    = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stall_ev    = 1'b1;
        end
    end

    // State register and flush down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            fl_left <= '0;
        end else begin
            state   <= state_nxt;
            fl_left <= fl_left_nxt;
        end
    end

    // Saturating statistics counters; clear outranks increment.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            busy_cnt  <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (busy_ev && (busy_cnt != '1)) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit (FLUSH_DEPTH=2, CNT_W=4).
module tb_hazard_unit;

    localparam int unsigned CW = 4;

    // Output pattern {ctrl_src, pc_write, if_id_write, if_id_flush, pipe_en}
    localparam logic [4:0] O_RST = 5'b10011;
    localparam logic [4:0] O_NRM = 5'b01101;
    localparam logic [4:0] O_LU  = 5'b10001;
    localparam logic [4:0] O_FL  = 5'b11111;
    localparam logic [4:0] O_BSY = 5'b00000;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    if_id_opcode;
    logic [4:0]    if_id_rs1, if_id_rs2, id_ex_rd;
    logic          id_ex_memread, branch_taken, dmem_busy, stat_clr;
    logic          ctrl_src, pc_write, if_id_write, if_id_flush, pipe_en;
    logic [CW-1:0] stall_cnt, flush_cnt, busy_cnt;

    typedef struct {
        string         tag;
        logic [4:0]    outs;
        logic [CW-1:0] sc, fc, bc;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] m_sc = '0, m_fc = '0, m_bc = '0;

    hazard_unit #(.FLUSH_DEPTH(2), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .if_id_opcode(if_id_opcode),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy), .stat_clr(stat_clr),
        .ctrl_src(ctrl_src), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .pipe_en(pipe_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Drive one cycle, push its expectation, compare mid-cycle, advance the model at the edge.
    task automatic step(input string tag, input logic rst, input logic [6:0] op,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic mr, input logic [4:0] rd,
                        input logic br, input logic bsy, input logic clr,
                        input logic [4:0] exp_outs);
        exp_t e, g;
        logic [4:0] obs;
        reset = rst; if_id_opcode = op; if_id_rs1 = r1; if_id_rs2 = r2;
        id_ex_memread = mr; id_ex_rd = rd; branch_taken = br;
        dmem_busy = bsy; stat_clr = clr;
        e.tag = tag; e.outs = exp_outs; e.sc = m_sc; e.fc = m_fc; e.bc = m_bc;
        sb.push_back(e);
        #3;
        g = sb.pop_front();
        obs = {ctrl_src, pc_write, if_id_write, if_id_flush, pipe_en};
        n_cmp++;
        assert (obs === g.outs) else begin
            n_err++;
            $error("FAIL %s outs: observed %b expected %b", g.tag, obs, g.outs);
        end
        n_cmp++;
        assert (stall_cnt === g.sc) else begin
            n_err++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", g.tag, stall_cnt, g.sc);
        end
        n_cmp++;
        assert (flush_cnt === g.fc) else begin
            n_err++;
            $error("FAIL %s flush_cnt: observed %0d expected %0d", g.tag, flush_cnt, g.fc);
        end
        n_cmp++;
        assert (busy_cnt === g.bc) else begin
            n_err++;
            $error("FAIL %s busy_cnt: observed %0d expected %0d", g.tag, busy_cnt, g.bc);
        end
        if (rst || clr) begin
            m_sc = '0; m_fc = '0; m_bc = '0;
        end else begin
            if (exp_outs == O_LU)  m_sc = sat_inc(m_sc);
            if (exp_outs[1])       m_fc = sat_inc(m_fc);
            if (exp_outs == O_BSY) m_bc = sat_inc(m_bc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; if_id_opcode = '0; if_id_rs1 = '0; if_id_rs2 = '0;
        id_ex_memread = 1'b0; id_ex_rd = '0; branch_taken = 1'b0;
        dmem_busy = 1'b0; stat_clr = 1'b0;
        @(posedge clk); #1;

        // Reset, then release with no hazards
        step("rst0", 1, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RST);
        step("rst1", 1, 7'b0110011, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RST);
        step("idle", 0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);

        // Load-use via rs2, then bubble clears memread
        step("lu_rs2",  0, 7'b0110011, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, O_LU);
        step("lu_bub",  0, 7'b0110011, 5'd1, 5'd5, 0, 5'd0, 0, 0, 0, O_NRM);
        step("lu_rd0",  0, 7'b0110011, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, O_NRM);
        step("imm_rs2", 0, 7'b0010011, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, O_NRM);
        step("ld_rs1",  0, 7'b0000011, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, O_LU);
        step("st_rs2",  0, 7'b0100011, 5'd2, 5'd9, 1, 5'd9, 0, 0, 0, O_LU);
        step("jal_no",  0, 7'b1101111, 5'd9, 5'd9, 1, 5'd9, 0, 0, 0, O_NRM);

        // Branch taken with a coincident load-use hazard
        step("br_lu0",  0, 7'b0110011, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, O_FL);
        step("br_lu1",  0, 7'b0110011, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, O_FL);
        step("br_end",  0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);

        // Clear coinciding with an increment
        step("clr_lu",  0, 7'b0110011, 5'd5, 5'd2, 1, 5'd5, 0, 0, 1, O_LU);

        // Branch, memory freeze on the second flush cycle, flush resumes
        step("bb_br",   0, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, O_FL);
        for (int unsigned i = 0; i < 3; i++)
            step("bb_busy", 0, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 1, 1, 0, O_BSY);
        step("bb_res",  0, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, O_FL);
        step("bb_end",  0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);

        // Freeze outranks a load-use hazard
        step("busy_lu", 0, 7'b0110011, 5'd5, 5'd2, 1, 5'd5, 0, 1, 0, O_BSY);

        // Stall counter saturation, then clear
        for (int unsigned i = 0; i < 20; i++)
            step("sat_lu", 0, 7'b0000011, 5'd4, 5'd0, 1, 5'd4, 0, 0, 0, O_LU);
        step("sat_chk", 0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, O_NRM);
        step("clr_chk", 0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);

        // Reset in the middle of FLUSH returns to RUN
        step("rf_br",   0, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0, O_FL);
        step("rf_rst",  1, 7'b1100011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_RST);
        step("rf_run",  0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);
        step("rf_idle", 0, 7'b0110011, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, O_NRM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller sitting directly upstream of CONTROL in the ID stage. It generates `ctrl_src` (which forces CONTROL's 8-bit output to zero, a bubble), plus PC/IF-ID write enables, IF/ID flush and a back-end freeze. It covers three cases: load-use stalls, multi-cycle branch-taken flushes for a deep fetch front end, and data-memory wait states. Saturating event counters are provided for performance debug.

## Interface
- `FLUSH_DEPTH`, 2: cycles of wrong-path flush after a taken branch (≥1)
- `CNT_W`, 16: width of the statistics counters
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `if_id_opcode` in 7: opcode of the instruction in IF/ID
- `if_id_rs1`, `if_id_rs2` in 5 each: source registers in IF/ID
- `id_ex_memread` in 1: MemRead bit (control[4]) held in ID/EX
- `id_ex_rd` in 5: destination register in ID/EX
- `branch_taken` in 1: branch resolved taken in EX this cycle
- `dmem_busy` in 1: data memory not ready; access in MEM must hold
- `stat_clr` in 1: synchronous clear of counters
- `ctrl_src` out 1: to CONTROL; 1 = zero all control bits into ID/EX
- `pc_write` out 1: PC register enable
- `if_id_write` out 1: IF/ID register enable
- `if_id_flush` out 1: load NOP into IF/ID
- `pipe_en` out 1: enable for ID/EX, EX/MEM, MEM/WB registers
- `stall_cnt` out CNT_W: load-use stall cycles
- `flush_cnt` out CNT_W: cycles with `if_id_flush`=1
- `busy_cnt` out CNT_W: cycles frozen by `dmem_busy`

## Operation
- Source usage:
  - rs1 is used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011.
  - rs2 is used for 0110011, 0100011, 1100011.
  - Any other opcode raises no hazard.
- `load_use` = `id_ex_memread` & (`id_ex_rd`≠0) & ((rs1 used & `id_ex_rd`==`if_id_rs1`) | (rs2 used & `id_ex_rd`==`if_id_rs2`)).
- FSM states: RUN, FLUSH. A down-counter `fl_left` has width clog2(FLUSH_DEPTH)+1.
- Outputs are combinational from state and inputs. Priority, high to low:
  - `reset`: ctrl_src=1, if_id_flush=1, pc_write=0, if_id_write=0, pipe_en=1.
  - `dmem_busy`=1 (any state): pc_write=0, if_id_write=0, pipe_en=0, ctrl_src=0, if_id_flush=0. State, `fl_left` and stall/flush counters hold.
  - FLUSH: ctrl_src=1, if_id_flush=1, pc_write=1, if_id_write=1, pipe_en=1. `branch_taken` and `load_use` are ignored.
  - RUN & `branch_taken`: ctrl_src=1, if_id_flush=1, pc_write=1 (loads target), if_id_write=1. `load_use` is ignored (wrong path).
  - RUN & `load_use`: ctrl_src=1, pc_write=0, if_id_write=0, if_id_flush=0.
  - Otherwise: ctrl_src=0, pc_write=1, if_id_write=1, if_id_flush=0, pipe_en=1.
- Transitions (only when `dmem_busy`=0):
  - RUN → FLUSH on `branch_taken` if FLUSH_DEPTH>1, with `fl_left`=FLUSH_DEPTH-1.
  - In FLUSH, `fl_left` decrements each cycle; FLUSH → RUN when `fl_left`==1.
- Counters:
  - `stall_cnt`++ on a RUN `load_use` cycle that wins priority.
  - `flush_cnt`++ when if_id_flush=1 and reset=0.
  - `busy_cnt`++ when the `dmem_busy` freeze wins.
  - All counters saturate at 2^CNT_W-1.
  - `stat_clr` zeroes all three; it outranks increment and is outranked by reset.

## Timing
- Reset: state=RUN, `fl_left`=0, all counters 0. Output values during reset are listed above. The first normal outputs appear in the cycle after `reset` deasserts.
- Load-use: exactly one bubble per load. The bubble in ID/EX clears `id_ex_memread` next cycle, so the stall self-terminates. No registered state is involved.
- Taken branch: flush lasts exactly FLUSH_DEPTH consecutive unfrozen cycles, starting in the `branch_taken` cycle.
- `dmem_busy` mid-flush stretches the flush in wall time but not in unfrozen-cycle count.
- Reset mid-FLUSH returns to RUN next cycle.
- `stat_clr` and an increment in the same cycle: counter = 0.

## Test plan
- Reset for 2 cycles, then release with no hazards → ctrl_src=0, pc_write=1, if_id_write=1, all counters 0.
- id_ex_memread=1, id_ex_rd=5, opcode 0110011, rs2=5 → one cycle of ctrl_src=1, pc_write=0, if_id_write=0; stall_cnt=1. Repeat with rd=0 → no stall.
- Same hazard but opcode 0010011 with rs2 field=5 → no stall (rs2 unused).
- FLUSH_DEPTH=2: branch_taken=1 together with load_use=1 → 2 cycles of if_id_flush=1 and ctrl_src=1, stall_cnt unchanged, flush_cnt=2.
- Branch taken, then dmem_busy=1 for 3 cycles on the second flush cycle → pipe_en=0 for 3 cycles, flush resumes for 1 cycle, busy_cnt=3, flush_cnt=2.
- CNT_W=4: 20 load-use stalls → stall_cnt=15. Then stat_clr → 0. Reset asserted during FLUSH → RUN next cycle.
